// File: rtl/lpc_frame_sched.sv
// lpc_frame_sched
//   Frame scheduler and register front-end for the LPC encoder datapath.
//   Counts input samples into frames of programmable length, starts the
//   encoder once per completed frame, waits for its completion and pulses a
//   coefficient-load strobe toward the decoder.
//
//   Optional feature macro: LPC_SCHED_TIMEOUT_EN adds the TMOLIM register
//   (address 4) and an ENCODE watchdog that sets STAT.TMO on expiry.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   sample_v          one pulse per accepted input sample
//   enc_done          encoder finished the current frame
//   address, read, write, writedata, readdata
//                     16-bit register port, readdata registered (latency 1)
//   enc_start         pulse: completed frame ready, start the encoder
//   coef_load         pulse: decoder latches the new coefficients
//   sample_idx        index of the next sample within the current frame
//   busy              high while in ENCODE
//   dbg_state         current FSM state (0 IDLE, 1 COLLECT, 2 ENCODE)
//
// Strobe semantics: there is no valid/ready back-pressure anywhere. Every
// input strobe is acted on in each cycle it is high and every output strobe
// is high for exactly one clk.
//
// Register map: 0 LEN (RW, shadowed), 1 CTRL (bit0 EN, bit1 CLR pulse),
//   2 STAT (bit0 busy, bit1 OVR W1C, bit2 TMO W1C), 3 FCNT (RO),
//   4 TMOLIM (RW, only with the macro). Other addresses read 0.

module lpc_frame_sched #(
    parameter int LEN_W   = 10,
    parameter int DEF_LEN = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_v,
    input  logic             enc_done,
    input  logic [15:0]      address,
    input  logic             read,
    input  logic             write,
    input  logic [15:0]      writedata,
    output logic [15:0]      readdata,
    output logic             enc_start,
    output logic             coef_load,
    output logic [LEN_W-1:0] sample_idx,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ENCODE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(16);

    state_t           state;
    logic [LEN_W-1:0] len_reg;   // software-visible shadow
    logic [LEN_W-1:0] len_act;   // length of the frame being collected
    logic             en;
    logic             ovr;
    logic [15:0]      fcnt;
    logic             tmo_bit;
    logic             frame_end;
    logic [LEN_W-1:0] wr_len;
    logic [LEN_W-1:0] wr_len_clamped;
    logic [15:0]      rd_mux;
    logic             unused_bits;

`ifdef LPC_SCHED_TIMEOUT_EN
    logic [15:0] tmolim;
    logic [15:0] wdog;
    logic        tmo;
    logic        wd_expire;
    assign wd_expire = (wdog == tmolim - 16'd1);
    assign tmo_bit   = tmo;
`else
    assign tmo_bit   = 1'b0;
`endif

    assign busy       = (state == ENCODE);
    assign dbg_state  = state;
    assign frame_end  = sample_v && (sample_idx == len_act - LEN_W'(1));

    // Truncate first, then clamp, so an oversized write can never yield 0.
    assign wr_len         = writedata[LEN_W-1:0];
    assign wr_len_clamped = (wr_len < MIN_LEN) ? MIN_LEN : wr_len;
    assign unused_bits    = ^writedata;

    always_comb begin
        rd_mux = 16'd0;
        case (address)
            16'd0: rd_mux = 16'(len_reg);
            16'd1: rd_mux = {15'd0, en};
            16'd2: rd_mux = {13'd0, tmo_bit, ovr, busy};
            16'd3: rd_mux = fcnt;
`ifdef LPC_SCHED_TIMEOUT_EN
            16'd4: rd_mux = tmolim;
`endif
            default: rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len_reg    <= LEN_W'(DEF_LEN);
            len_act    <= LEN_W'(DEF_LEN);
            en         <= 1'b0;
            ovr        <= 1'b0;
            fcnt       <= 16'd0;
            sample_idx <= '0;
            readdata   <= 16'd0;
            enc_start  <= 1'b0;
            coef_load  <= 1'b0;
`ifdef LPC_SCHED_TIMEOUT_EN
            tmolim     <= 16'hFFFF;
            wdog       <= 16'd0;
            tmo        <= 1'b0;
`endif
        end else begin
            enc_start <= 1'b0;
            coef_load <= 1'b0;

            if (read) begin
                readdata <= rd_mux;
            end

            case (state)
                IDLE: begin
                    sample_idx <= '0;
                    if (en) begin
                        len_act <= len_reg;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (frame_end) begin
                        sample_idx <= '0;
                        len_act    <= len_reg;
                        enc_start  <= 1'b1;
                        state      <= ENCODE;
`ifdef LPC_SCHED_TIMEOUT_EN
                        wdog       <= 16'd0;
`endif
                    end else if (sample_v) begin
                        sample_idx <= sample_idx + LEN_W'(1);
                    end
                end
                ENCODE: begin
`ifdef LPC_SCHED_TIMEOUT_EN
                    wdog <= wdog + 16'd1;
`endif
                    // Sampling continues into the next frame while encoding.
                    if (frame_end) begin
                        sample_idx <= '0;
                        len_act    <= len_reg;
                    end else if (sample_v) begin
                        sample_idx <= sample_idx + LEN_W'(1);
                    end

                    if (enc_done) begin
                        coef_load <= 1'b1;
                        fcnt      <= fcnt + 16'd1;
                        if (frame_end) begin
                            // Back-to-back: the new frame goes straight in.
                            enc_start <= 1'b1;
`ifdef LPC_SCHED_TIMEOUT_EN
                            wdog      <= 16'd0;
`endif
                        end else begin
                            state <= COLLECT;
                        end
`ifdef LPC_SCHED_TIMEOUT_EN
                    end else if (wd_expire) begin
                        tmo <= 1'b1;
                        if (frame_end) begin
                            // Abandoned encode frees the encoder for this frame.
                            enc_start <= 1'b1;
                            wdog      <= 16'd0;
                        end else begin
                            state <= COLLECT;
                        end
`endif
                    end else if (frame_end) begin
                        ovr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Register writes take priority over same-cycle FSM activity.
            if (write) begin
                case (address)
                    16'd0: len_reg <= wr_len_clamped;
                    16'd1: begin
                        en <= writedata[0];
                        if (writedata[1]) begin
                            sample_idx <= '0;
                            fcnt       <= 16'd0;
                            ovr        <= 1'b0;
                            enc_start  <= 1'b0;
                            coef_load  <= 1'b0;
`ifdef LPC_SCHED_TIMEOUT_EN
                            tmo        <= 1'b0;
`endif
                            if (writedata[0]) begin
                                len_act <= len_reg;
                                state   <= COLLECT;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (!writedata[0]) begin
                            sample_idx <= '0;
                            enc_start  <= 1'b0;
                            coef_load  <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    16'd2: begin
                        if (writedata[1]) ovr <= 1'b0;
`ifdef LPC_SCHED_TIMEOUT_EN
                        if (writedata[2]) tmo <= 1'b0;
`endif
                    end
`ifdef LPC_SCHED_TIMEOUT_EN
                    16'd4: tmolim <= writedata;
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/lpc_frame_sched.md
# lpc_frame_sched

Frame scheduler and register front-end for the LPC encoder datapath. It counts input samples into analysis frames of programmable length, starts the encoder once per completed frame, waits for completion, and pulses a coefficient-load strobe toward the decoder. It also owns the 16-bit memory-mapped register port (address/read/write/writedata/readdata) that software and the bench use to program the frame length and observe status.

## Interface
- `LEN_W`, default 10: width of the frame-length register and sample counter; max frame length is 2^LEN_W − 1.
- `DEF_LEN`, default 240: frame length after reset (30 ms at 8 kHz).
- `clk`  in  1  system clock (50 MHz); all logic on rising edge.
- `rst`  in  1  asynchronous active-low reset; assertion clears all state at once, deassertion is synchronous to `clk`.
- `sample_v`  in  1  one-`clk` pulse per accepted input sample (8 kHz tick, already synchronized).
- `enc_done`  in  1  one-`clk` pulse from the encoder: coefficients for the current frame are valid.
- `address`  in  16  register address.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `writedata`  in  16  write data.
- `readdata`  out  16  read data, registered.
- `enc_start`  out  1  one-`clk` pulse: the frame just completed is ready; start the encoder.
- `coef_load`  out  1  one-`clk` pulse: decoder latches A0..A10/voiced/pulse rate.
- `sample_idx`  out  LEN_W  index of the next sample within the current frame.
- `busy`  out  1  high while the encoder runs (state ENCODE).

## Operation
- Registers (word addresses; others read 0, writes ignored):
  - 0 LEN: RW, reset `DEF_LEN`. Writes below 16 clamp to 16; upper bits beyond LEN_W are dropped. Shadowed: the active length is loaded only at frame start.
  - 1 CTRL: RW; bit0 EN (reset 0), bit1 CLR (write-1 pulse; always reads 0).
  - 2 STAT: bit0 busy (RO), bit1 OVR sticky (W1C), bit2 TMO sticky (W1C, only with the macro).
  - 3 FCNT: RO; count of completed frames (coef_load pulses), 16-bit, wraps at 0xFFFF→0. Cleared by CLR.
- States:
  - IDLE: the counter is held at 0. When EN=1, load the active length and go to COLLECT.
  - COLLECT: each `sample_v` increments `sample_idx`. On the sample with idx = len−1: assert `enc_start`, reset idx to 0, reload the active length, and go to ENCODE.
  - ENCODE: samples keep being counted into the next frame. On `enc_done`: assert `coef_load`, increment FCNT, and go to COLLECT.
    - If the next frame completes before `enc_done` arrives: set OVR, drop that frame (no `enc_start`), restart idx at 0, and stay in ENCODE.
- Simultaneous `enc_done` and frame-complete in ENCODE: assert `coef_load` and `enc_start` in the same cycle, do not set OVR, and stay in ENCODE.
- EN written 0 in any state: go to IDLE next cycle, clear idx, and suppress any later `enc_done`.
- CLR: clear idx, FCNT and the sticky bits, and go to COLLECT if EN=1, otherwise IDLE.
  - A CLR write that also carries EN=1 enables and clears together.
- `sample_v` in IDLE is ignored.

## Timing
- Reset values: readdata=0, enc_start=0, coef_load=0, sample_idx=0, busy=0, state IDLE.
- Write takes effect on the `clk` edge where `write`=1. Reads are single-cycle latency: `readdata` is valid the `clk` after `read`, and holds its value otherwise.
- `enc_start` is asserted on the cycle after the completing `sample_v`.
- `coef_load` is asserted on the cycle after `enc_done`. `busy` changes on the same edge as the state change.
- No back-pressure; every strobe is a single cycle. Multi-cycle inputs count once per cycle high.

## Configuration
- `LPC_SCHED_TIMEOUT_EN` defined:
  - Adds register 4 TMOLIM (RW, reset 0xFFFF) and a 16-bit watchdog cleared on entry to ENCODE.
  - If TMOLIM cycles pass in ENCODE with no `enc_done`: set STAT.TMO and go to COLLECT without `coef_load`. A late `enc_done` is then ignored.
- Not defined: no watchdog, address 4 reads 0, STAT bit2 reads 0, and ENCODE waits indefinitely.

## Test plan
- Reset, then write LEN=240, CTRL=1, then 240 `sample_v` pulses → one `enc_start` exactly 1 cycle after the 240th pulse, and `sample_idx` returns to 0.
- `enc_done` 500 cycles after `enc_start` → `coef_load` 1 cycle later, FCNT reads 1, busy falls.
- Withhold `enc_done` for 481 samples with LEN=240 → STAT reads 0x0003 while busy; the second frame produces no `enc_start`; write STAT=0x0002 → reads 0x0001.
- `enc_done` coincident with the 240th sample of the next frame → `coef_load` and `enc_start` in the same cycle, and OVR stays 0.
- Write LEN=5 mid-frame → the current frame still ends at 240 and the next at 16 (clamped); a read of addr 0 returns 16 at latency 1.
- With `LPC_SCHED_TIMEOUT_EN`, set TMOLIM=100 and no `enc_done` → STAT bit2 is set 100 cycles after `enc_start`, and an `enc_done` asserted later produces no `coef_load`.
